// File: rtl/spi_nor_flash_target_pkg.sv
// Shared types and constants for the SPI NOR flash READ responder.
// The JEDEC ID constants only take effect when SPI_NOR_TARGET_JEDEC_ID_EN is defined.
package spi_nor_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_ID,
    ST_IGNORE
  } state_t;

  localparam logic [7:0]  OPC_READ  = 8'h03;
  localparam logic [7:0]  OPC_JEDEC = 8'h9F;
  localparam logic [23:0] JEDEC_ID  = 24'hEF4018;

endpackage

// File: rtl/spi_nor_flash_target_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall detect
// on the synchronized value. The chain clears to 0 on reset.
module spi_nor_target_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   q_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      chain <= '0;
      q_d   <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      q_d   <= chain[SYNC_STAGES-1];
    end
  end

  assign q    = chain[SYNC_STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/spi_nor_flash_target.sv
// SPI mode-0 NOR flash responder answering READ (0x03) from a byte-wide memory port.
// Define SPI_NOR_TARGET_JEDEC_ID_EN to also answer JEDEC ID (0x9F).
module spi_nor_flash_target
  import spi_nor_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 24
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              bad_cmd
);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s;

  spi_nor_target_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .resetn(resetn), .din(spi_cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  spi_nor_target_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .resetn(resetn), .din(spi_sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_nor_target_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .resetn(resetn), .din(spi_mosi), .q(mosi_s), .rise(), .fall()
  );

  state_t      state, state_n;
  logic [2:0]  bit_cnt;
  logic [4:0]  addr_cnt;
  logic [23:0] rx;
  logic [7:0]  tx_sr, next_sr;
  logic        rd_en_p1, reload, armed;
  logic [7:0]  opcode;
  logic [23:0] rx_next;

  assign opcode  = {rx[6:0], mosi_s};
  assign rx_next = {rx[22:0], mosi_s};
  // Until CS has been seen high once, a low CS belongs to a frame abandoned by reset.
  assign busy    = armed & ~cs_s;

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (cs_s) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) state_n = ST_CMD;
        ST_CMD: begin
          if (sclk_rise && bit_cnt == 3'd0) begin
            if (opcode == OPC_READ) state_n = ST_ADDR;
`ifdef SPI_NOR_TARGET_JEDEC_ID_EN
            else if (opcode == OPC_JEDEC) state_n = ST_ID;
`endif
            else state_n = ST_IGNORE;
          end
        end
        ST_ADDR: if (rd_en_p1) state_n = ST_DATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      spi_miso  <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      bad_cmd   <= 1'b0;
      rd_en_p1  <= 1'b0;
      reload    <= 1'b0;
      armed     <= 1'b0;
      bit_cnt   <= '0;
      addr_cnt  <= '0;
      rx        <= '0;
      tx_sr     <= '0;
      next_sr   <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      bad_cmd   <= 1'b0;
      rd_en_p1  <= mem_rd_en;
      if (cs_rise) armed <= 1'b1;
      if (cs_s) begin
        spi_miso <= 1'b0;
        rd_en_p1 <= 1'b0;
        reload   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              bit_cnt  <= 3'd7;
              spi_miso <= 1'b0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              rx      <= rx_next;
              bit_cnt <= bit_cnt - 3'd1;
              if (bit_cnt == 3'd0) begin
                if (opcode == OPC_READ) addr_cnt <= 5'd23;
`ifdef SPI_NOR_TARGET_JEDEC_ID_EN
                else if (opcode == OPC_JEDEC) rx <= JEDEC_ID;
`endif
                else bad_cmd <= 1'b1;
              end
            end
          end
          ST_ADDR: begin
            if (sclk_rise) begin
              rx       <= rx_next;
              addr_cnt <= addr_cnt - 5'd1;
              if (addr_cnt == 5'd0) begin
                mem_addr  <= rx_next[ADDR_W-1:0];
                mem_rd_en <= 1'b1;
              end
            end
            if (rd_en_p1) begin
              tx_sr   <= mem_rdata;
              bit_cnt <= 3'd7;
              reload  <= 1'b0;
            end
          end
          ST_DATA: begin
            // Prefetched byte waits in next_sr until the fall that starts the next byte.
            if (rd_en_p1) next_sr <= mem_rdata;
            if (sclk_fall) begin
              if (reload) begin
                spi_miso <= next_sr[7];
                tx_sr    <= {next_sr[6:0], 1'b0};
                reload   <= 1'b0;
              end else begin
                spi_miso <= tx_sr[7];
                tx_sr    <= {tx_sr[6:0], 1'b0};
              end
              bit_cnt <= bit_cnt - 3'd1;
              if (bit_cnt == 3'd0) begin
                mem_addr  <= mem_addr + ADDR_W'(1);
                mem_rd_en <= 1'b1;
                reload    <= 1'b1;
              end
            end
          end
`ifdef SPI_NOR_TARGET_JEDEC_ID_EN
          ST_ID: begin
            if (sclk_fall) begin
              spi_miso <= rx[23];
              rx       <= {rx[22:0], 1'b0};
            end
          end
`endif
          ST_IGNORE: spi_miso <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_nor_flash_target.sv
// Self-checking bench for spi_nor_flash_target: SPI master tasks, memory model
// mem[a] = a[7:0]^8'hA5, and a byte-level reference model of the READ response.
module tb_spi_nor_flash_target;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        mem_rd_en;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;
  logic        bad_cmd;

  int n_cmp = 0;
  int n_fail = 0;
  int half = 4;
  int bad_cnt = 0;
  logic [23:0] fetch_q[$];

  spi_nor_flash_target #(.SYNC_STAGES(2), .ADDR_W(24)) dut (
    .clk(clk), .resetn(resetn), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy), .bad_cmd(bad_cmd)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_byte(mem_addr);

  always @(negedge clk) begin
    if (mem_rd_en) fetch_q.push_back(mem_addr);
    if (bad_cmd) bad_cnt++;
  end

  // Reference: MISO bits of a READ frame, MSB-aligned at bit 63 (first 32 bits are zero).
  function automatic logic [63:0] exp_read_bits(input logic [23:0] addr, input int nbytes);
    logic [63:0] v = '0;
    for (int j = 0; j < 8 * nbytes; j++) begin
      logic [7:0] b = mem_byte(addr + 24'(j / 8));
      v[31 - j] = b[7 - (j % 8)];
    end
    return v;
  endfunction

  // One fetch for the address phase plus one per data bit 0 driven (falls after every rise).
  function automatic int exp_nfetch(input int nbytes);
    int n = 1;
    for (int m = 0; m <= 8 * nbytes; m++) if (m % 8 == 7) n++;
    return n;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_begin();
    spi_cs = 1'b0;
    wait_clks(half);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    wait_clks(half);
    spi_sclk = 1'b1;
    m = spi_miso;
    wait_clks(half);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_end();
    wait_clks(half);
    spi_cs = 1'b1;
    spi_mosi = 1'b0;
    wait_clks(half + 4);
  endtask

  task automatic spi_frame(input int nbits, input logic [63:0] mosi_v, output logic [63:0] miso_v);
    logic m;
    miso_v = '0;
    spi_begin();
    for (int i = 0; i < nbits; i++) begin
      spi_bit(mosi_v[63 - i], m);
      miso_v[63 - i] = m;
    end
    spi_end();
  endtask

  task automatic do_read(input logic [23:0] addr, input int nbytes, output logic [63:0] miso_v);
    fetch_q.delete();
    spi_frame(32 + 8 * nbytes, {8'h03, addr, 32'h0}, miso_v);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    wait_clks(4);
    n_cmp += 5;
    if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso got=%b want=0", spi_miso); end
    if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%b want=0", mem_rd_en); end
    if (mem_addr !== 24'h0) begin n_fail++; $display("FAIL reset_addr got=%h want=000000", mem_addr); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (bad_cmd !== 1'b0) begin n_fail++; $display("FAIL reset_bad_cmd got=%b want=0", bad_cmd); end
    resetn = 1'b1;
    wait_clks(8);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_read_basic();
    logic [63:0] mv;
    logic [31:0] le;
    int nf;
    do_read(24'h000100, 4, mv);
    le = {mv[7:0], mv[15:8], mv[23:16], mv[31:24]};
    n_cmp += 2;
    if (le !== 32'hA6A7A4A5) begin n_fail++; $display("FAIL basic_data got=%h want=a6a7a4a5", le); end
    if (mv[63:32] !== 32'h0) begin n_fail++; $display("FAIL basic_hdr_miso got=%h want=0", mv[63:32]); end
    nf = exp_nfetch(4);
    n_cmp++;
    if (fetch_q.size() != nf) begin
      n_fail++; $display("FAIL basic_nfetch got=%0d want=%0d", fetch_q.size(), nf);
    end else begin
      for (int k = 0; k < nf; k++) begin
        n_cmp++;
        if (fetch_q[k] !== 24'h000100 + 24'(k)) begin
          n_fail++; $display("FAIL basic_addr%0d got=%h want=%h", k, fetch_q[k], 24'h000100 + 24'(k));
        end
      end
    end
  endtask

  task automatic test_read_wrap();
    logic [63:0] mv;
    logic [23:0] want_a [4] = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
    do_read(24'hFFFFFE, 4, mv);
    n_cmp++;
    if (mv[31:0] !== 32'h5B5AA5A4) begin n_fail++; $display("FAIL wrap_data got=%h want=5b5aa5a4", mv[31:0]); end
    n_cmp++;
    if (fetch_q.size() < 4) begin
      n_fail++; $display("FAIL wrap_nfetch got=%0d want>=4", fetch_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (fetch_q[k] !== want_a[k]) begin
          n_fail++; $display("FAIL wrap_addr%0d got=%h want=%h", k, fetch_q[k], want_a[k]);
        end
      end
    end
  endtask

  task automatic test_read_random();
    logic [63:0] mv, ev;
    logic [23:0] a;
    int nb;
    for (int it = 0; it < 8; it++) begin
      half = $urandom_range(6, 4);
      a = 24'($urandom);
      nb = $urandom_range(4, 1);
      do_read(a, nb, mv);
      ev = exp_read_bits(a, nb);
      n_cmp += 2;
      if (mv !== ev) begin n_fail++; $display("FAIL rand_data%0d addr=%h got=%h want=%h", it, a, mv, ev); end
      if (fetch_q.size() != exp_nfetch(nb) || fetch_q[0] !== a || fetch_q[fetch_q.size()-1] !== a + 24'(exp_nfetch(nb) - 1)) begin
        n_fail++; $display("FAIL rand_fetch%0d addr=%h got_n=%0d want_n=%0d", it, a, fetch_q.size(), exp_nfetch(nb));
      end
    end
    half = 4;
  endtask

  task automatic test_bad_cmd();
    logic [7:0] ops [2];
    logic m;
    logic [31:0] mv;
    ops[0] = 8'h05;
    do ops[1] = 8'($urandom);
`ifdef SPI_NOR_TARGET_JEDEC_ID_EN
    while (ops[1] == 8'h03 || ops[1] == 8'h9F);
`else
    while (ops[1] == 8'h03);
`endif
    for (int t = 0; t < 2; t++) begin
      bad_cnt = 0;
      fetch_q.delete();
      mv = '0;
      spi_begin();
      n_cmp++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL bad_busy_hi op=%h got=%b want=1", ops[t], busy); end
      for (int i = 0; i < 8; i++) spi_bit(ops[t][7 - i], m);
      n_cmp++;
      if (bad_cnt != 1) begin n_fail++; $display("FAIL bad_pulse op=%h got=%0d want=1", ops[t], bad_cnt); end
      for (int i = 0; i < 24; i++) begin
        spi_bit(1'($urandom), m);
        mv[31 - i] = m;
      end
      spi_end();
      n_cmp += 4;
      if (mv !== 32'h0) begin n_fail++; $display("FAIL bad_miso op=%h got=%h want=0", ops[t], mv); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_busy_lo op=%h got=%b want=0", ops[t], busy); end
      if (bad_cnt != 1) begin n_fail++; $display("FAIL bad_once op=%h got=%0d want=1", ops[t], bad_cnt); end
      if (fetch_q.size() != 0) begin n_fail++; $display("FAIL bad_nofetch op=%h got=%0d want=0", ops[t], fetch_q.size()); end
    end
  endtask

  task automatic test_abort();
    logic [19:0] hdr = {8'h03, 12'hABC};
    logic m;
    logic [63:0] mv, ev;
    fetch_q.delete();
    spi_begin();
    for (int i = 0; i < 20; i++) spi_bit(hdr[19 - i], m);
    spi_end();
    n_cmp += 2;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b want=0", busy); end
    if (fetch_q.size() != 0) begin n_fail++; $display("FAIL abort_nofetch got=%0d want=0", fetch_q.size()); end
    do_read(24'h000010, 2, mv);
    ev = exp_read_bits(24'h000010, 2);
    n_cmp += 2;
    if (mv[31:24] !== 8'hB5) begin n_fail++; $display("FAIL abort_first got=%h want=b5", mv[31:24]); end
    if (mv !== ev) begin n_fail++; $display("FAIL abort_read got=%h want=%h", mv, ev); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] hdr = {8'h03, 24'h000200};
    logic m;
    logic [63:0] mv, ev;
    spi_begin();
    for (int i = 0; i < 32; i++) spi_bit(hdr[31 - i], m);
    for (int i = 0; i < 13; i++) spi_bit(1'b0, m);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    n_cmp += 3;
    if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL rstmid_miso got=%b want=0", spi_miso); end
    if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd_en got=%b want=0", mem_rd_en); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    wait_clks(3);
    spi_cs = 1'b1;
    wait_clks(2);
    resetn = 1'b1;
    wait_clks(8);
    do_read(24'h0003F0, 3, mv);
    ev = exp_read_bits(24'h0003F0, 3);
    n_cmp++;
    if (mv !== ev) begin n_fail++; $display("FAIL rstmid_read got=%h want=%h", mv, ev); end
  endtask

  task automatic test_jedec();
    logic [7:0] op = 8'h9F;
    logic m;
    logic [31:0] mv = '0;
    bad_cnt = 0;
    fetch_q.delete();
    spi_begin();
    for (int i = 0; i < 8; i++) spi_bit(op[7 - i], m);
    for (int i = 0; i < 32; i++) begin
      spi_bit(1'b0, m);
      mv[31 - i] = m;
    end
    spi_end();
    n_cmp += 3;
    if (fetch_q.size() != 0) begin n_fail++; $display("FAIL jedec_nofetch got=%0d want=0", fetch_q.size()); end
`ifdef SPI_NOR_TARGET_JEDEC_ID_EN
    if (mv !== 32'hEF401800) begin n_fail++; $display("FAIL jedec_id got=%h want=ef401800", mv); end
    if (bad_cnt != 0) begin n_fail++; $display("FAIL jedec_bad got=%0d want=0", bad_cnt); end
`else
    if (mv !== 32'h0) begin n_fail++; $display("FAIL jedec_miso got=%h want=0", mv); end
    if (bad_cnt != 1) begin n_fail++; $display("FAIL jedec_bad got=%0d want=1", bad_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [63:0] mv, ev;
    logic [23:0] a;
    for (int t = 0; t < 2; t++) begin
      a = 24'h00FFFC + 24'(t * 3);
      do_read(a, 4, mv);
      ev = exp_read_bits(a, 4);
      n_cmp++;
      if (mv !== ev) begin n_fail++; $display("FAIL b2b%0d got=%h want=%h", t, mv, ev); end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_basic();
    test_read_wrap();
    test_read_random();
    test_bad_cmd();
    test_abort();
    test_reset_mid();
    test_jedec();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
